// File: rtl/dac_tx_pkg.sv
// -----------------------------------------------------------------------------
// dac_tx_pkg
// Shared definitions for the DAC sample transmitter:
//   CH_W      - bits per DAC channel
//   NUM_CH    - channels packed in one sample word (lane k at [k*CH_W +: CH_W])
//   SAMPLE_W  - full sample word width
//   tx_state_t- transmitter FSM encoding (IDLE=0, PRIME=1, RUN=2)
// Helpers build a whole sample word from per-lane codes.
// Optional feature macro: DAC_TX_TEST_PATTERN_EN (adds the ramp helper).
// -----------------------------------------------------------------------------
package dac_tx_pkg;

   localparam int CH_W     = 12;
   localparam int NUM_CH   = 4;
   localparam int SAMPLE_W = CH_W * NUM_CH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } tx_state_t;

   // Same code replicated on every lane (mid-scale idle output).
   function automatic logic [SAMPLE_W-1:0] fill_lanes(input logic [CH_W-1:0] code);
      fill_lanes = {NUM_CH{code}};
   endfunction

`ifdef DAC_TX_TEST_PATTERN_EN
   // Lane k carries ramp + k*1024; the add wraps naturally at CH_W bits.
   function automatic logic [SAMPLE_W-1:0] ramp_lanes(input logic [CH_W-1:0] ramp);
      logic [SAMPLE_W-1:0] word;
      word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         word[k*CH_W +: CH_W] = ramp + CH_W'(k * 1024);
      end
      ramp_lanes = word;
   endfunction
`endif

endpackage

// File: rtl/sample_fifo.sv
// -----------------------------------------------------------------------------
// sample_fifo
// Synchronous first-word-fall-through FIFO with occupancy output.
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset (empties the FIFO)
//   flush  - synchronous discard of all contents; wins over push/pop
//   push   - write wdata (ignored when full)
//   wdata  - write word
//   pop    - consume the head word (ignored when empty)
//   rdata  - head word, valid whenever empty=0 (no read latency)
//   level  - current occupancy, 0..DEPTH
//   full   - level == DEPTH
//   empty  - level == 0
// DEPTH must be a power of two so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module sample_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 48,
   localparam int LVL_W = $clog2(DEPTH + 1),
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [W-1:0]     wdata,
   input  logic             pop,
   output logic [W-1:0]     rdata,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LVL_W'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: the storage array is deliberately not reset; level/pointers alone
   // decide what is valid, and leaving it reset-free lets it map to RAM.
   always_ff @(posedge clk) begin
      if (do_push && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/dac_sample_tx.sv
// -----------------------------------------------------------------------------
// dac_sample_tx
// Buffers 4-channel sample words and streams them to a DAC bus, one word per
// clock, once the buffer is primed. Idle/prime/underflow cycles show the
// mid-scale IDLE_CODE on all lanes.
//   clk           - sample clock, rising edge
//   rst           - synchronous active-high reset
//   en            - streaming enable; dropping it returns to IDLE and flushes
//   s_valid       - input word valid
//   s_ready       - input word accepted this cycle (combinational)
//   s_data        - {ch_d, ch_c, ch_b, ch_a}, 12 bits each
//   dac_data      - registered DAC bus, same lane mapping as s_data
//   dac_sync      - high on the first word after each PRIME->RUN entry
//   underflow     - sticky; set when RUN finds the FIFO empty, cleared on
//                   IDLE->PRIME
//   underflow_cnt - saturating underflow event count, cleared only by rst
//   fifo_level    - FIFO occupancy
//   state         - FSM state (IDLE=0, PRIME=1, RUN=2)
//   pattern_sel   - (DAC_TX_TEST_PATTERN_EN only) in RUN, output a ramp test
//                   pattern instead of FIFO data
// Optional feature macro: DAC_TX_TEST_PATTERN_EN.
// -----------------------------------------------------------------------------
module dac_sample_tx
   import dac_tx_pkg::*;
#(
   parameter  int              FIFO_DEPTH  = 8,
   parameter  int              PRIME_LEVEL = 4,
   parameter  logic [CH_W-1:0] IDLE_CODE   = 12'h800,
   localparam int              LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
`ifdef DAC_TX_TEST_PATTERN_EN
   input  logic                pattern_sel,
`endif
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [SAMPLE_W-1:0] s_data,
   output logic [SAMPLE_W-1:0] dac_data,
   output logic                dac_sync,
   output logic                underflow,
   output logic [15:0]         underflow_cnt,
   output logic [LVL_W-1:0]    fifo_level,
   output logic [1:0]          state
);

   tx_state_t           state_q;
   tx_state_t           state_d;
   logic                first_q;      // first RUN cycle after PRIME
   logic [SAMPLE_W-1:0] dac_data_d;
   logic                dac_sync_d;
   logic                uf_event;
   logic                fifo_pop;
   logic                fifo_flush;
   logic                fifo_full;
   logic                fifo_empty;
   logic [SAMPLE_W-1:0] fifo_rdata;
   logic                fifo_push;

`ifdef DAC_TX_TEST_PATTERN_EN
   logic [CH_W-1:0]     ramp_q;
`endif

   assign state     = state_q;
   // A full FIFO refuses input even when it is popping in the same cycle.
   assign s_ready   = (state_q != ST_IDLE) && !fifo_full;
   assign fifo_push = s_valid && s_ready;

   sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (SAMPLE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .wdata (s_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // NOTE: every signal written here gets a default first so no path through
   // the case leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d    = state_q;
      dac_data_d = fill_lanes(IDLE_CODE);
      dac_sync_d = 1'b0;
      uf_event   = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            fifo_flush = 1'b1;
            if (en) state_d = ST_PRIME;
         end

         ST_PRIME: begin
            if (!en) begin
               state_d    = ST_IDLE;
               fifo_flush = 1'b1;
            end else if (fifo_level >= LVL_W'(PRIME_LEVEL)) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!en) begin
               // Flush now so fifo_level already reads 0 in the IDLE cycle.
               state_d    = ST_IDLE;
               fifo_flush = 1'b1;
`ifdef DAC_TX_TEST_PATTERN_EN
            end else if (pattern_sel) begin
               dac_data_d = ramp_lanes(ramp_q);
               dac_sync_d = first_q;
`endif
            end else if (fifo_empty) begin
               state_d  = ST_PRIME;
               uf_event = 1'b1;
            end else begin
               fifo_pop   = 1'b1;
               dac_data_d = fifo_rdata;
               dac_sync_d = first_q;
            end
         end

         default: begin
            state_d    = ST_IDLE;
            fifo_flush = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         first_q       <= 1'b0;
         dac_data      <= fill_lanes(IDLE_CODE);
         dac_sync      <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         state_q  <= state_d;
         // RUN is only entered with at least PRIME_LEVEL words buffered, so
         // the first RUN cycle always produces a real word to mark.
         first_q  <= (state_q == ST_PRIME) && (state_d == ST_RUN);
         dac_data <= dac_data_d;
         dac_sync <= dac_sync_d;

         if ((state_q == ST_IDLE) && (state_d == ST_PRIME)) begin
            underflow <= 1'b0;
         end else if (uf_event) begin
            underflow <= 1'b1;
         end

         if (uf_event && (underflow_cnt != 16'hFFFF)) begin
            underflow_cnt <= underflow_cnt + 16'd1;
         end
      end
   end

`ifdef DAC_TX_TEST_PATTERN_EN
   // Ramp sits at 0 outside RUN so the first RUN cycle shows ramp value 0.
   always_ff @(posedge clk) begin
      if (rst || (state_q != ST_RUN)) begin
         ramp_q <= '0;
      end else begin
         ramp_q <= ramp_q + CH_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_dac_sample_tx.sv
// -----------------------------------------------------------------------------
// tb_dac_sample_tx
// Directed bench for dac_sample_tx. Two instances share clk/rst:
//   dut   - default parameters (start, underflow, stop, reset, pattern)
//   dut8  - PRIME_LEVEL=8 (backpressure with a full FIFO)
// Optional feature macro: DAC_TX_TEST_PATTERN_EN (enables the pattern case).
// -----------------------------------------------------------------------------
module tb_dac_sample_tx;

   localparam logic [47:0] IDLE_W = 48'h800800800800;
   localparam logic [47:0] W0     = 48'h001002003004;
   localparam logic [47:0] U0     = 48'hA00A01A02A03;
   localparam logic [47:0] X0     = 48'h111222333444;
   localparam logic [47:0] Y0     = 48'h0F00E00D00C0;
   localparam logic [47:0] B0     = 48'h500600700800;

   logic        clk = 1'b0;
   logic        rst;

   logic        en, s_valid, s_ready, dac_sync, underflow;
   logic [47:0] s_data, dac_data;
   logic [15:0] underflow_cnt;
   logic [3:0]  fifo_level;
   logic [1:0]  state;

   logic        en8, v8, ready8, sync8, uf8;
   logic [47:0] d8, data8;
   logic [15:0] cnt8;
   logic [3:0]  lvl8;
   logic [1:0]  st8;

`ifdef DAC_TX_TEST_PATTERN_EN
   logic        pattern_sel;
   logic        pattern_sel8;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dac_sample_tx dut (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
`ifdef DAC_TX_TEST_PATTERN_EN
      .pattern_sel   (pattern_sel),
`endif
      .s_valid       (s_valid),
      .s_ready       (s_ready),
      .s_data        (s_data),
      .dac_data      (dac_data),
      .dac_sync      (dac_sync),
      .underflow     (underflow),
      .underflow_cnt (underflow_cnt),
      .fifo_level    (fifo_level),
      .state         (state)
   );

   dac_sample_tx #(.PRIME_LEVEL(8)) dut8 (
      .clk           (clk),
      .rst           (rst),
      .en            (en8),
`ifdef DAC_TX_TEST_PATTERN_EN
      .pattern_sel   (pattern_sel8),
`endif
      .s_valid       (v8),
      .s_ready       (ready8),
      .s_data        (d8),
      .dac_data      (data8),
      .dac_sync      (sync8),
      .underflow     (uf8),
      .underflow_cnt (cnt8),
      .fifo_level    (lvl8),
      .state         (st8)
   );

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input logic [47:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b1;
         s_data  = base + 48'(i);
         tick();
      end
      s_valid = 1'b0;
   endtask

   int   acc;
   int   outn;
   logic took;

   initial begin
      rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_data = '0;
      en8 = 1'b0; v8 = 1'b0; d8 = '0;
`ifdef DAC_TX_TEST_PATTERN_EN
      pattern_sel = 1'b0; pattern_sel8 = 1'b0;
`endif

      // ---------------- reset ----------------
      tick(); tick();
      check("rst_data",   dac_data,      IDLE_W);
      check("rst_ready",  s_ready,       0);
      check("rst_state",  state,         0);
      check("rst_cnt",    underflow_cnt, 0);
      check("rst_uf",     underflow,     0);
      check("rst_sync",   dac_sync,      0);
      check("rst_level",  fifo_level,    0);
      rst = 1'b0;

      // ---------------- start: six words ----------------
      en = 1'b1;
      tick();
      check("prime_state", state,   1);
      check("prime_ready", s_ready, 1);
      for (int i = 0; i < 6; i++) begin
         s_valid = 1'b1;
         s_data  = W0 + 48'(i);
         tick();
         if (i == 3) begin
            check("primed_state", state,      1);
            check("primed_level", fifo_level, 4);
         end
         if (i == 4) check("run_state", state, 2);
         if (i == 5) begin
            check("first_sync",  dac_sync,   1);
            check("first_word",  dac_data,   W0);
            check("run_level",   fifo_level, 5);
         end
      end
      s_valid = 1'b0;
      for (int i = 1; i < 6; i++) begin
         tick();
         check("stream_word", dac_data, W0 + 48'(i));
         check("stream_sync", dac_sync, 0);
      end
      check("drained_level", fifo_level, 0);
      tick();
      check("uf1_data",  dac_data,      IDLE_W);
      check("uf1_flag",  underflow,     1);
      check("uf1_cnt",   underflow_cnt, 1);
      check("uf1_state", state,         1);

      // ---------------- stop mid-RUN ----------------
      push_words(U0, 4);
      check("stop_primed", fifo_level, 4);
      tick();
      check("stop_run", state, 2);
      tick();
      check("stop_word", dac_data,   U0);
      check("stop_sync", dac_sync,   1);
      check("stop_lvl3", fifo_level, 3);
      en = 1'b0;
      tick();
      check("stop_state", state,      0);
      check("stop_data",  dac_data,   IDLE_W);
      check("stop_level", fifo_level, 0);
      check("stop_ready", s_ready,    0);
      en = 1'b1;
      tick();
      check("restart_state", state,         1);
      check("restart_uf",    underflow,     0);
      check("restart_cnt",   underflow_cnt, 1);

      // ---------------- reset mid-RUN ----------------
      push_words(X0, 4);
      tick();
      tick();
      check("mid_word", dac_data, X0);
      rst = 1'b1;
      tick();
      check("mrst_state", state,         0);
      check("mrst_level", fifo_level,    0);
      check("mrst_data",  dac_data,      IDLE_W);
      check("mrst_cnt",   underflow_cnt, 0);
      check("mrst_ready", s_ready,       0);
      tick();
      rst = 1'b0;
      tick();
      check("post_rst_state", state, 1);

      // ---------------- underflow: exactly four words ----------------
      push_words(Y0, 4);
      tick();
      check("uf_run", state, 2);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("uf_word", dac_data, Y0 + 48'(i));
         check("uf_sync", dac_sync, (i == 0) ? 48'd1 : 48'd0);
      end
      tick();
      check("uf_data",  dac_data,      IDLE_W);
      check("uf_flag",  underflow,     1);
      check("uf_cnt",   underflow_cnt, 1);
      check("uf_state", state,         1);

`ifdef DAC_TX_TEST_PATTERN_EN
      // ---------------- test pattern ----------------
      pattern_sel = 1'b1;
      push_words(W0, 4);
      tick();
      check("pat_run", state, 2);
      tick();
      check("pat_w0",  dac_data,   48'hC00800400000);
      check("pat_lv0", fifo_level, 4);
      tick();
      check("pat_w1",  dac_data,   48'hC01801401001);
      check("pat_lv1", fifo_level, 4);
      pattern_sel = 1'b0;
`endif
      en = 1'b0;
      tick();

      // ---------------- backpressure (PRIME_LEVEL=8) ----------------
      en8 = 1'b1;
      tick();
      check("bp_prime", st8, 1);
      acc  = 0;
      outn = 0;
      v8   = 1'b1;
      d8   = B0;
      for (int cyc = 0; cyc < 40 && outn < 10; cyc++) begin
         took = v8 && ready8;
         tick();
         if (outn > 0 || sync8) begin
            check("bp_word", data8, B0 + 48'(outn));
            outn++;
         end
         if (took) begin
            acc++;
            if (acc == 8) check("bp_full_ready", ready8, 0);
            if (acc < 10) d8 = B0 + 48'(acc);
            else          v8 = 1'b0;
         end
      end
      check("bp_accepted", acc,  10);
      check("bp_emitted",  outn, 10);
      tick();
      check("bp_uf", uf8, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dac_sample_tx.md
DAC_SAMPLE_TX -- requirements
Module: dac_sample_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, sample buffer depth in words (power of two, >=2).
REQ-002 SHALL have parameter PRIME_LEVEL, default 4, FIFO level required before streaming starts (1..FIFO_DEPTH).
REQ-003 SHALL have parameter IDLE_CODE, default 12'h800, per-channel mid-scale code driven when not streaming.
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports clk and rst.
REQ-005 SHALL have port clk  input  1  sample clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port en  input  1  streaming enable.
REQ-008 SHALL have port s_valid  input  1  input sample word valid.
REQ-009 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-010 SHALL have port s_data  input  48  {ch_d[47:36], ch_c[35:24], ch_b[23:12], ch_a[11:0]}.
REQ-011 SHALL have port dac_data  output  48  registered DAC bus, same lane mapping as s_data; feeds output LVDS buffers.
REQ-012 SHALL have port dac_sync  output  1  one-cycle frame marker.
REQ-013 SHALL have port underflow  output  1  sticky underflow flag.
REQ-014 SHALL have port underflow_cnt  output  16  saturating underflow event count.
REQ-015 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-016 SHALL have port state  output  2  FSM state for debug (IDLE=0, PRIME=1, RUN=2).

Function
REQ-017 SHALL write FIFO when s_valid && s_ready; s_ready = (state != IDLE) && (fifo_level < FIFO_DEPTH), combinational.
REQ-018 SHALL, in IDLE: drive dac_data = IDLE_CODE on all four lanes, hold FIFO empty (flushed on entry), go to PRIME when en=1.
REQ-019 SHALL, in PRIME: drive IDLE_CODE lanes, not pop; go to RUN when fifo_level >= PRIME_LEVEL; en=0 has priority -> IDLE.
REQ-020 SHALL, in RUN: pop one word per cycle; popped word appears on dac_data at the next rising edge (latency 1).
REQ-021 SHALL assert dac_sync for exactly the cycle dac_data shows the first word after each PRIME->RUN transition.
REQ-022 SHALL, in RUN with FIFO empty: drive IDLE_CODE lanes next cycle, set underflow, increment underflow_cnt (saturate at 16'hFFFF), go to PRIME.
REQ-023 SHALL allow simultaneous push and pop in RUN; level unchanged; full FIFO with pop still reports s_ready=0 that cycle.
REQ-024 SHALL, on en=0 in RUN: go to IDLE next cycle, IDLE_CODE lanes from that cycle on, discard FIFO contents.
REQ-025 SHALL clear underflow on the IDLE->PRIME transition; underflow_cnt cleared only by rst.

Reset
REQ-026 SHALL on rst=1 set state=IDLE, fifo_level=0, dac_data=all lanes IDLE_CODE, dac_sync=0, underflow=0, underflow_cnt=0, s_ready=0.
REQ-027 SHALL let rst override all other inputs, including mid-RUN; in-flight FIFO data discarded.

Configuration
REQ-028 SHALL, with DAC_TX_TEST_PATTERN_EN defined, add input pattern_sel (1 bit); in RUN with pattern_sel=1, lane k = (ramp + k*12'h400) mod 4096, ramp incrementing by 1 per cycle from 0 at RUN entry; FIFO not popped, no underflow.
REQ-029 SHALL, without DAC_TX_TEST_PATTERN_EN, omit pattern_sel and ramp logic entirely; behaviour per REQ-017..025.

Structure
REQ-030 SHALL place CH_W=12, NUM_CH=4, SAMPLE_W=48 and the state enum in shared package dac_tx_pkg.
REQ-031 SHALL implement buffering in one sub-module sample_fifo (synchronous, first-word-fall-through, level output).

Verification
REQ-032 SHALL cover reset: rst 2 cycles -> dac_data=48'h800800800800, s_ready=0, state=0, underflow_cnt=0.
REQ-033 SHALL cover start: en=1, push 48'h001002003004..+1 x6 -> RUN after level 4, dac_sync with dac_data=48'h001002003004, then consecutive words.
REQ-034 SHALL cover underflow: push exactly 4 words, stop -> after 4th word dac_data=48'h800800800800, underflow=1, underflow_cnt=1, state=1.
REQ-035 SHALL cover backpressure: PRIME_LEVEL=8, push 10 words back-to-back -> s_ready=0 after 8th accept; no word lost or duplicated on dac_data.
REQ-036 SHALL cover stop mid-RUN: en=0 -> next cycle state=0, IDLE_CODE lanes, fifo_level=0; en=1 again clears underflow.
REQ-037 SHALL cover pattern (macro defined): pattern_sel=1, 4 words primed -> dac_data lanes 000/400/800/C00, then 001/401/801/C01; fifo_level stays 4.
